out_display: RTL and testbench



---
 rtl/out_display_pkg.sv | 59 +++++
 rtl/out_display_bin_to_bcd.sv | 88 ++++++++
 rtl/out_display.sv | 99 +++++++++
 tb/tb_out_display.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/out_display_pkg.sv
// Shared definitions for the output display stage: conversion FSM encoding,
// seven-segment patterns and the elaboration-time digit-count helper.
package out_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Smallest decimal digit count able to hold 2^width-1.
  function automatic int min_digits(input int width);
    longint unsigned max_v;
    longint unsigned pow10;
    int              n;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    pow10 = 64'd10;
    n     = 1;
    for (int i = 0; i < 19; i++) begin
      if (pow10 <= max_v) begin
        pow10 = pow10 * 64'd10;
        n     = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/out_display_bin_to_bcd.sv
// Sequential double-dabble converter: one shift per clock, restartable at any
// time; the result register only changes when a conversion runs to completion.
module out_display_bin_to_bcd
  import out_display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  conv_state_e           state_q, state_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [4*DIGITS-1:0]   adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;

    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end

    if (start_i) begin
      // A new write always wins, silently dropping any conversion in flight.
      bin_d   = bin_i;
      acc_d   = '0;
      cnt_d   = CNT_W'(WIDTH);
      state_d = ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          {acc_d, bin_d} = {adj[4*DIGITS-2:0], bin_q, 1'b0};
          cnt_d          = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          bcd_d   = acc_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/out_display.sv
// Output-port display stage: samples CPU output writes, converts to BCD and
// scans a multiplexed 7-segment display with leading-zero blanking.
module out_display
  import out_display_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_load_enable,
  input  logic [WIDTH-1:0]      i_load_data,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_an,
  output logic [6:0]            o_seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("out_display: DIGITS too small to hold 2^WIDTH-1");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("out_display: SCAN_DIV must be at least 1");
  end

  logic                  sample;
  logic [4*DIGITS-1:0]   bcd;

  // Only the write strobe is gated by clk_en; conversion and scan run on raw clk.
  assign sample = clk_en && i_load_enable;

  out_display_bin_to_bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin_to_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (sample),
    .bin_i   (i_load_data),
    .busy_o  (o_busy),
    .done_o  (o_valid),
    .bcd_o   (bcd)
  );

  assign o_bcd = bcd;

  logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         digit;
  logic               all_zero;
  logic               blank;

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Blank a digit when it and everything above it are zero; digit 0 always shows.
    all_zero = 1'b1;
    blank    = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (bcd[4*k +: 4] == 4'd0);
      if ((int'(idx_d) == k) && all_zero) blank = 1'b1;
    end

    digit = bcd[{idx_d, 2'b00} +: 4];
    seg_d = blank ? SEG_BLANK : seg_decode(digit);
    an_d  = DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= DIGITS'(1);
      seg_q      <= SEG_0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display with a short scan period so full display
// rotations fit in a few dozen cycles.
module tb_out_display;

  localparam int W  = 16;
  localparam int D  = 5;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          ld;
  logic [W-1:0]  data;
  logic          busy;
  logic          valid;
  logic [4*D-1:0] bcd;
  logic [D-1:0]  an;
  logic [6:0]    seg;

  int checks = 0;
  int errors = 0;

  out_display #(
    .WIDTH    (W),
    .DIGITS   (D),
    .SCAN_DIV (SD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .i_load_enable (ld),
    .i_load_data   (data),
    .o_busy        (busy),
    .o_valid       (valid),
    .o_bcd         (bcd),
    .o_an          (an),
    .o_seg         (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [W-1:0] v);
    clk_en = 1'b1;
    ld     = 1'b1;
    data   = v;
    tick();
    ld     = 1'b0;
  endtask

  // Expected segments packed as digit k at [7k +: 7].
  task automatic sweep(input string tag, input logic [34:0] exp_segs);
    logic [D-1:0] seen;
    int           idx;
    seen = '0;
    for (int t = 0; t < SD * D; t++) begin
      tick();
      idx = -1;
      for (int k = 0; k < D; k++) if (an == D'(1) << k) idx = k;
      if (idx < 0) begin
        check({tag, "_onehot"}, 32'(an), 32'(1));
      end else begin
        seen[idx] = 1'b1;
        check({tag, "_seg"}, 32'(seg), 32'(exp_segs[7*idx +: 7]));
      end
    end
    check({tag, "_all_digits"}, 32'(seen), 32'h1F);
  endtask

  // Conversion latency: sample at edge N, result at edge N+17.
  task automatic convert(input string tag, input logic [W-1:0] v,
                         input logic [4*D-1:0] old_bcd, input logic [4*D-1:0] exp_bcd);
    sample(v);
    check({tag, "_busy0"}, 32'(busy), 32'(1));
    for (int k = 1; k <= 16; k++) begin
      tick();
      check({tag, "_busy"}, 32'(busy), 32'(1));
      check({tag, "_novalid"}, 32'(valid), 32'(0));
      check({tag, "_hold"}, 32'(bcd), 32'(old_bcd));
    end
    tick();
    check({tag, "_valid"}, 32'(valid), 32'(1));
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, "_idle"}, 32'(busy), 32'(0));
    tick();
    check({tag, "_pulse"}, 32'(valid), 32'(0));
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    ld     = 1'b0;
    data   = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", 32'(busy), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_bcd", 32'(bcd), 32'(0));
    check("rst_an", 32'(an), 32'(1));
    check("rst_seg", 32'(seg), 32'h3F);

    // Idle scan: digit index advances every SD cycles from the reset edge.
    for (int t = 1; t <= 44; t++) begin
      int ei;
      tick();
      ei = (t / SD) % D;
      check("idle_an", 32'(an), 32'(1 << ei));
      check("idle_seg", 32'(seg), (ei == 0) ? 32'h3F : 32'h00);
      check("idle_valid", 32'(valid), 32'(0));
    end
    check("idle_bcd", 32'(bcd), 32'(0));

    convert("ffff", 16'hFFFF, 20'h00000, 20'h65535);
    sweep("sw65535", {7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h6D});

    // 1234 is overridden by 42 five cycles later.
    sample(16'd1234);
    for (int k = 0; k < 4; k++) tick();
    convert("abort", 16'd42, 20'h65535, 20'h00042);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("abort_late", 32'(valid), 32'(0));
    end
    check("abort_bcd", 32'(bcd), 32'h00042);
    sweep("sw42", {7'h00, 7'h00, 7'h00, 7'h66, 7'h5B});

    // clk_en low: the strobe must be ignored.
    clk_en = 1'b0;
    ld     = 1'b1;
    data   = 16'd999;
    for (int k = 0; k < 50; k++) begin
      tick();
      check("gate_busy", 32'(busy), 32'(0));
      check("gate_valid", 32'(valid), 32'(0));
    end
    ld = 1'b0;
    check("gate_bcd", 32'(bcd), 32'h00042);

    // Restart while in the DONE cycle: no pulse, old result kept.
    sample(16'd100);
    for (int k = 0; k < 16; k++) tick();
    check("done_busy", 32'(busy), 32'(1));
    convert("done_abort", 16'd300, 20'h00042, 20'h00300);

    convert("ten_k", 16'd10000, 20'h00300, 20'h10000);
    sweep("sw10000", {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F});

    // Reset and sample in the same cycle: reset wins.
    rst    = 1'b1;
    clk_en = 1'b1;
    ld     = 1'b1;
    data   = 16'd5;
    tick();
    rst = 1'b0;
    ld  = 1'b0;
    check("rstld_busy", 32'(busy), 32'(0));
    check("rstld_bcd", 32'(bcd), 32'(0));
    for (int k = 0; k < 20; k++) begin
      tick();
      check("rstld_valid", 32'(valid), 32'(0));
    end

    // Reset at cycle 8 of a conversion of 999.
    convert("pre999", 16'd10000, 20'h00000, 20'h10000);
    sample(16'd999);
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(valid), 32'(0));
    check("midrst_bcd", 32'(bcd), 32'(0));
    check("midrst_an", 32'(an), 32'(1));
    check("midrst_seg", 32'(seg), 32'h3F);
    check("midrst_busy", 32'(busy), 32'(0));
    for (int k = 0; k < 20; k++) begin
      tick();
      check("midrst_quiet", 32'(valid), 32'(0));
    end
    check("midrst_hold", 32'(bcd), 32'(0));

    convert("seven", 16'd7, 20'h00000, 20'h00007);
    sweep("sw7", {7'h00, 7'h00, 7'h00, 7'h00, 7'h07});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
